mem_write_combiner: RTL
=======================

// Module: mem_write_combiner
// PURPOSE
// - Sits upstream of the PSRAM memory controller on the framebuffer write path. It collects
//   16-bit pixel writes from the rasterizer into 64-bit, 4-pixel bursts and issues one
//   mem_write per burst.
// - Each write command to the PSRAM then carries 8 bytes, not 2.
// - A double buffer (staging + issue) lets pixel intake continue while a burst waits out the controller gap.
// PARAMETERS
// - WR_GAP  24     min clk2 cycles from one mem_write pulse to the next (>=1); covers controller write time
// - FILL    16'h0  value written to lanes never written in a partial (flushed/evicted) burst
// PORTS
// - clk2        in   1   block clock; mem_* request port lives in this domain
// - rst         in   1   synchronous, active-high reset
// - px_valid    in   1   pixel write request
// - px_ready    out  1   pixel accepted when px_valid & px_ready (combinational)
// - px_addr     in   22  pixel address; [21:2]=burst tag, [1:0]=lane
// - px_data     in   16  pixel value
// - flush       in   1   level; while high, intake stops and partial staging is pushed out
// - idle        out  1   staging empty, issue reg empty, FSM in IDLE
// - mem_addr    out  20  burst address (= tag), registered
// - mem_write   out  1   one-cycle write request pulse
// - mem_wrdata  out  64  burst data, registered; lane0=[63:48] ... lane3=[15:0]
// BEHAVIOUR
// - Staging: tag[19:0], mask[3:0], data[63:0]. Accepted pixel writes lane px_addr[1:0] and sets its mask bit.
//   A repeat write to the same lane overwrites it (last wins).
// - Issue reg: valid, tag, data. When staging moves to issue, unmasked lanes are replaced by FILL.
// - Move staging->issue when the issue reg is free, or is cleared by an issue in the same cycle, and one of:
//   (a) mask becomes 4'b1111: the completing pixel goes into the move, staging empties;
//   (b) accepted px tag != staging tag with mask!=0: old staging moves, new pixel starts fresh staging same cycle;
//   (c) flush=1 and mask!=0.
// - px_ready = !flush & !(mask!=0 & tag!=px_addr[21:2] & issue_busy). issue_busy = issue.valid & !issuing_this_cycle.
//   A completing pixel (a) with issue_busy also drops px_ready.
// - Issue FSM:
//   IDLE: if issue.valid -> mem_write=1 for one cycle; latch mem_addr/mem_wrdata; clear issue.valid;
//         cnt=WR_GAP-1; go to GAP, or stay in IDLE if WR_GAP==1.
//   GAP: cnt-- each cycle; at cnt==0 -> IDLE. mem_addr/mem_wrdata hold stable until the next issue.
// - Issue throughput: one issue per WR_GAP cycles. Back-to-back full bursts: mem_write pulses exactly WR_GAP apart.
// - Reset mid-operation discards staging and issue contents (no write emitted).
//   After reset: px_ready=1, idle=1, mem_write=0, mem_addr=0, mem_wrdata=0, mask=0, FSM IDLE.
// - Simultaneous px_valid & flush: the pixel is not accepted (px_ready=0); the flush proceeds.
// - Tag arithmetic has no wrap issues: the tag is an opaque 20-bit compare.
// CONFIGURATION
// - MEM_WC_STATS_EN defined: adds outputs stat_full[15:0] and stat_partial[15:0].
//   stat_full increments on each issue with mask 1111; stat_partial increments on other issues.
//   Both saturate at 16'hFFFF and reset to 0.
// - MEM_WC_STATS_EN undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
// - Full burst: px 0x000004..07 with data 1,2,3,4 -> one mem_write; addr=0x00001, wrdata=64'h0001_0002_0003_0004.
// - Partial flush: px 0x000011 data AAAA, then flush=1 -> mem_write addr=0x00004,
//   wrdata=64'h0000_AAAA_0000_0000; idle=1 after.
// - Tag eviction: px 0x000000=11, then px 0x000008=22 -> old burst issued with 64'h0011_0000_0000_0000;
//   new pixel kept staged.
// - Backpressure: 3 full bursts back-to-back -> pulses WR_GAP apart; px_ready low while staging
//   is full and issue busy; no data lost.
// - Reset mid-GAP with staging half full -> no further mem_write; outputs at reset values next cycle.
// - Stats (MEM_WC_STATS_EN): 2 full + 1 partial bursts -> stat_full=2, stat_partial=1.

Source files
------------

// File: rtl/mem_write_combiner.sv
// Framebuffer write combiner: packs 16-bit pixel writes into 64-bit 4-lane bursts for the PSRAM controller.
// Optional statistics counters are enabled by defining MEM_WC_STATS_EN.
module mem_write_combiner #(
    parameter int unsigned WR_GAP = 24,
    parameter logic [15:0] FILL   = 16'h0
) (
    input  logic        clk2,
    input  logic        rst,
    input  logic        px_valid,
    output logic        px_ready,
    input  logic [21:0] px_addr,
    input  logic [15:0] px_data,
    input  logic        flush,
    output logic        idle,
    output logic [19:0] mem_addr,
    output logic        mem_write,
    output logic [63:0] mem_wrdata
`ifdef MEM_WC_STATS_EN
    ,
    output logic [15:0] stat_full,
    output logic [15:0] stat_partial
`endif
);

    localparam int CNT_W = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_GAP  = 1'b1
    } state_t;

    // Staging buffer: collects lanes of the burst currently being assembled.
    logic [19:0] r_stg_tag;
    logic [3:0]  r_stg_mask;
    logic [63:0] r_stg_data;

    // Issue buffer: one complete burst waiting for the controller gap to expire.
    logic        r_iss_valid;
    logic [19:0] r_iss_tag;
    logic [63:0] r_iss_data;

    state_t          r_state;
    logic [CNT_W-1:0] r_cnt;
    logic            r_mem_write;
    logic [19:0]     r_mem_addr;
    logic [63:0]     r_mem_wrdata;

    logic [19:0] w_px_tag;
    logic [1:0]  w_px_lane;
    logic [3:0]  w_lane_bit;
    logic        w_issuing;
    logic        w_issue_busy;
    logic        w_stg_any;
    logic        w_tag_miss;
    logic        w_completes;
    logic        w_accept;
    logic        w_move_full;
    logic        w_move_evict;
    logic        w_move_flush;
    logic        w_move;
    logic [63:0] w_merged_data;
    logic [63:0] w_move_data;

    // Lane 0 sits in the most significant halfword of the burst.
    function automatic logic [63:0] put_lane(input logic [63:0] d, input logic [1:0] lane,
                                             input logic [15:0] v);
        logic [63:0] r;
        r = d;
        case (lane)
            2'd0:    r[63:48] = v;
            2'd1:    r[47:32] = v;
            2'd2:    r[31:16] = v;
            default: r[15:0]  = v;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] fill_lanes(input logic [63:0] d, input logic [3:0] m);
        logic [63:0] r;
        r = d;
        for (int i = 0; i < 4; i++) begin
            if (!m[i]) r[63-16*i -: 16] = FILL;
        end
        return r;
    endfunction

    assign w_px_tag     = px_addr[21:2];
    assign w_px_lane    = px_addr[1:0];
    assign w_lane_bit   = 4'b0001 << w_px_lane;
    assign w_issuing    = (r_state == S_IDLE) && r_iss_valid;
    assign w_issue_busy = r_iss_valid && !w_issuing;
    assign w_stg_any    = |r_stg_mask;
    assign w_tag_miss   = w_stg_any && (r_stg_tag != w_px_tag);
    assign w_completes  = !w_tag_miss && ((r_stg_mask | w_lane_bit) == 4'b1111);

    // A pixel that would need to push staging into a still-occupied issue buffer must wait.
    assign px_ready = !flush
                    && !(w_tag_miss && w_issue_busy)
                    && !(w_completes && w_issue_busy);
    assign w_accept = px_valid && px_ready;

    assign w_move_full  = w_accept && w_completes;
    assign w_move_evict = w_accept && w_tag_miss;
    assign w_move_flush = flush && w_stg_any && !w_issue_busy;
    assign w_move       = w_move_full || w_move_evict || w_move_flush;

    // NOTE: every always_comb output is assigned at the top so no path can leave it unassigned and infer a latch.
    always_comb begin
        w_merged_data = put_lane(r_stg_data, w_px_lane, px_data);
        w_move_data   = fill_lanes(r_stg_data, r_stg_mask);
        if (w_move_full) w_move_data = w_merged_data;
    end

    // NOTE: data registers are reset too, because mem_addr/mem_wrdata are defined to read 0 after reset.
    always_ff @(posedge clk2) begin
        if (rst) begin
            r_stg_tag   <= '0;
            r_stg_mask  <= '0;
            r_stg_data  <= '0;
            r_iss_valid <= 1'b0;
            r_iss_tag   <= '0;
            r_iss_data  <= '0;
        end else begin
            if (w_accept) begin
                r_stg_tag  <= w_px_tag;
                r_stg_data <= w_merged_data;
                if (w_move_full)       r_stg_mask <= '0;
                else if (w_move_evict) r_stg_mask <= w_lane_bit;
                else                   r_stg_mask <= r_stg_mask | w_lane_bit;
            end else if (w_move_flush) begin
                r_stg_mask <= '0;
            end

            if (w_move) begin
                r_iss_valid <= 1'b1;
                r_iss_tag   <= r_stg_tag;
                r_iss_data  <= w_move_data;
            end else if (w_issuing) begin
                r_iss_valid <= 1'b0;
            end
        end
    end

    // Issue FSM: one write pulse, then WR_GAP-1 quiet cycles before the next may go.
    always_ff @(posedge clk2) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wrdata <= '0;
        end else begin
            r_mem_write <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_iss_valid) begin
                        r_mem_write  <= 1'b1;
                        r_mem_addr   <= r_iss_tag;
                        r_mem_wrdata <= r_iss_data;
                        r_cnt        <= CNT_W'(WR_GAP - 1);
                        if (WR_GAP > 1) r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt <= CNT_W'(1)) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_write  = r_mem_write;
    assign mem_addr   = r_mem_addr;
    assign mem_wrdata = r_mem_wrdata;
    assign idle       = !w_stg_any && !r_iss_valid && (r_state == S_IDLE);

`ifdef MEM_WC_STATS_EN
    logic        r_iss_full;
    logic [15:0] r_stat_full;
    logic [15:0] r_stat_partial;

    always_ff @(posedge clk2) begin
        if (rst) begin
            r_iss_full     <= 1'b0;
            r_stat_full    <= '0;
            r_stat_partial <= '0;
        end else begin
            if (w_move) r_iss_full <= w_move_full;
            if (w_issuing) begin
                if (r_iss_full) begin
                    if (r_stat_full != 16'hFFFF) r_stat_full <= r_stat_full + 16'd1;
                end else begin
                    if (r_stat_partial != 16'hFFFF) r_stat_partial <= r_stat_partial + 16'd1;
                end
            end
        end
    end

    assign stat_full    = r_stat_full;
    assign stat_partial = r_stat_partial;
`endif

endmodule
